sub_bytes_iter: RTL and testbench
=================================

# sub_bytes_iter

Sequential AES SubBytes stage that sits directly upstream of `shiftRows` in the cipher round datapath. It accepts one 4×4 byte state over a valid/ready handshake and substitutes its bytes through a configurable number of shared S-box lanes. It then presents the substituted state, in the same `[col][row]` layout that `shiftRows` consumes, through a second valid/ready handshake. The block trades throughput for area: the S-box logic is reused across `16/LANES` cycles.

## Interface
- `LANES`, default 4: S-box instances, i.e. bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `i_valid`  in  1  input state valid
- `i_ready`  out  1  block can accept a state
- `state`  in  8 × [0:3][0:3]  input state, `state[c][r]` (column c, row r)
- `o_valid`  out  1  output state valid
- `o_ready`  in  1  downstream accepts output
- `o`  out  8 × [0:3][0:3]  substituted state, same layout as `state`

## Operation
- FSM states and outputs:
  - IDLE: `i_ready=1`, `o_valid=0`.
  - BUSY: `i_ready=0`, `o_valid=0`.
  - DONE: `i_ready=0`, `o_valid=1`.
- Reset: asynchronous. While `rst` is high:
  - FSM = IDLE, byte index `idx=0`, working register = all 0x00.
  - Outputs: `i_ready=1`, `o_valid=0`, `o`=all 0x00.
- IDLE, with `i_valid & i_ready` at an edge:
  - Capture `state` into the working register.
  - Set `idx=0` and go to BUSY.
- BUSY, on every edge:
  - Replace working bytes k = idx … idx+LANES−1 with S(byte).
  - Linear byte index k = 4·c + r, so byte k is `state[k/4][k%4]` (column-major).
  - `idx += LANES`.
  - Go to DONE on the edge that processes k = 15.
  - `idx` width is 4 bits. It wraps to 0 after the final step and is never used beyond 15.
- DONE:
  - `o` = working register, held stable while `o_valid=1` and `o_ready=0`.
  - On an edge with `o_ready=1`, go to IDLE.
- `o` drives the working register at all times. Its contents in IDLE/BUSY are don't-care for downstream, except for the reset value.
- Input side in BUSY/DONE: `i_valid` is ignored because `i_ready=0`, and `state` changes there have no effect.
- Simultaneous events: in DONE with `o_ready=1` and `i_valid=1`, the new input is not accepted on that edge; it is accepted in IDLE one cycle later. No input/output overlap.
- Reset asserted in BUSY or DONE aborts the operation immediately. The partial state is discarded and no `o_valid` pulse is produced.
- S-box: FIPS-197 forward S-box, purely combinational, indexed by the 8-bit byte. No inverse mode.

## Timing
- Let N = 16/LANES.
- Input accepted at edge 0.
- BUSY occupies edges 1…N. `o_valid` rises after edge N, so latency from acceptance to `o_valid` is N cycles.
- Minimum initiation interval is N+2 cycles, with `o_ready` tied high.
- Examples:
  - LANES=4: latency 4, interval 6.
  - LANES=16: latency 1, interval 3.
- No combinational path exists from `o_ready` to `o_valid`/`o`, or from `i_valid` to `i_ready`.
- All outputs are registered or decoded directly from FSM state.

## Structure
- Shared AES package (used by `shiftRows`, MixColumns and AddRoundKey):
  - byte type (8 bits)
  - state type (4×4 bytes, `[col][row]`)
  - 256-entry forward S-box constant table
  - NB=4 constant
- Sub-module `aes_sbox`: one byte in, one byte out, combinational table lookup, instantiated LANES times.
- Lane j addresses working byte idx+j through a 16:1 byte mux. When LANES=16 the mux reduces to a direct connection.

## Test plan
- Single byte values, LANES=1: states of all 0x00, all 0x01, all 0x53 and all 0xFF give `o` of all 0x63, 0x7C, 0xED and 0x16 respectively, with `o_valid` exactly 16 cycles after acceptance.
- FIPS-197 Appendix B, round 1, LANES=4:
  - Input columns {19 3d e3 be}{a0 f4 e2 2b}{9a c6 8d 2a}{e9 f8 48 08}.
  - Required `o` columns {d4 27 11 ae}{e0 bf 98 f1}{b8 b4 5d e5}{1e 41 52 30}, `o_valid` after 4 cycles.
- Backpressure: hold `o_ready=0` for 10 cycles in DONE. `o` and `o_valid` stay stable and `i_ready` stays 0 throughout. Release, then `i_ready=1` on the next cycle.
- Back-to-back, LANES=16, `o_ready`=1, `i_valid` held high with a new state each accept: accepts occur every 3 cycles and outputs match per-state reference values in order.
- Reset mid-BUSY, LANES=1: assert `rst` at byte 7.
  - Immediately: `o`=all 0x00, `i_ready=1`, no `o_valid`.
  - Next state after reset fully converts correctly.
- Parameter sweep: LANES ∈ {1,2,4,8,16} against a random-state scoreboard of 1000 states. All match, and latency equals 16/LANES.

Source files
------------

// File: rtl/sub_bytes_iter_pkg.sv
// Shared AES definitions: byte/state types, the forward S-box table and the FSM encoding
// used by the iterative SubBytes stage.
package sub_bytes_iter_pkg;

   localparam int NB = 4;

   typedef logic [7:0] byte_t;
   // Column-major AES state: [col][row], matching shiftRows.
   typedef byte_t [0:NB-1][0:3] state_t;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} fsm_e;

   localparam byte_t SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/aes_sbox.sv
// Single forward AES S-box lane: combinational table lookup.
module aes_sbox
   import sub_bytes_iter_pkg::*;
(
   input  byte_t in_i,
   output byte_t out_o
);

   assign out_o = SBOX[in_i];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: one state in, LANES bytes substituted per cycle through shared
// S-boxes, substituted state out, both sides valid/ready.
module sub_bytes_iter
   import sub_bytes_iter_pkg::*;
#(
   parameter int unsigned LANES = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   i_valid,
   output logic   i_ready,
   input  state_t state,
   output logic   o_valid,
   input  logic   o_ready,
   output state_t o
);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad
      $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
   end

   fsm_e       state_q, state_d;
   logic [3:0] idx_q, idx_d;
   state_t     work_q, work_d;
   logic       last_step;

   logic [3:0] lane_idx [LANES];
   byte_t      sbox_out [LANES];

   // Byte k = 4*col + row, so idx[3:2] selects the column and idx[1:0] the row.
   for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign lane_idx[j] = idx_q + 4'(j);
      aes_sbox u_sbox (
         .in_i  (work_q[lane_idx[j][3:2]][lane_idx[j][1:0]]),
         .out_o (sbox_out[j])
      );
   end

   assign last_step = (idx_q == 4'(16 - LANES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         work_q  <= work_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (i_valid)   state_d = StBusy;
         StBusy:  if (last_step) state_d = StDone;
         StDone:  if (o_ready)   state_d = StIdle;
         default:                state_d = StIdle;
      endcase
   end

   always_comb begin
      work_d = work_q;
      idx_d  = idx_q;
      if (state_q == StIdle && i_valid) begin
         work_d = state;
         idx_d  = '0;
      end else if (state_q == StBusy) begin
         for (int unsigned j = 0; j < LANES; j++) begin
            work_d[lane_idx[j][3:2]][lane_idx[j][1:0]] = sbox_out[j];
         end
         idx_d = idx_q + 4'(LANES);
      end
   end

   always_comb begin
      i_ready = (state_q == StIdle);
      o_valid = (state_q == StDone);
      o       = work_q;
   end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench: five DUTs (LANES 1..16) share a clock/reset; expected states are queued
// at acceptance and checked by a monitor when each DUT presents o_valid.
module tb_sub_bytes_iter;
   import sub_bytes_iter_pkg::*;

   localparam int NI = 5;
   localparam int LANES_TAB [NI] = '{1, 2, 4, 8, 16};

   logic          clk = 1'b0;
   logic          rst;
   logic [NI-1:0] iv, ir, ov, orr;
   logic [NI-1:0] ov_prev;
   state_t        st, exp_next;
   state_t        o_w [NI];

   state_t        exp_q [NI][$];
   int            acc_q [NI][$];
   int            cyc = 0;
   int            n_chk = 0;
   int            n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      sub_bytes_iter #(.LANES(LANES_TAB[g])) u_dut (
         .clk     (clk),
         .rst     (rst),
         .i_valid (iv[g]),
         .i_ready (ir[g]),
         .state   (st),
         .o_valid (ov[g]),
         .o_ready (orr[g]),
         .o       (o_w[g])
      );
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   task automatic fail(input string name);
      n_chk++;
      $display("FAIL %s: event did not occur as required", name);
   endtask

   function automatic byte_t gmul(input byte_t a, input byte_t b);
      byte_t p = 8'h00;
      byte_t x = a;
      byte_t y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   // Reference S-box: GF(2^8) inverse (a^254) followed by the affine map.
   function automatic byte_t ref_s(input byte_t a);
      byte_t sq = a;
      byte_t r  = 8'h01;
      byte_t b;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      b = r;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
             ^ 8'h63;
   endfunction

   function automatic state_t ref_state(input state_t s);
      state_t r;
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 4; k++) r[c][k] = ref_s(s[c][k]);
      return r;
   endfunction

   function automatic state_t fill(input byte_t b);
      state_t r;
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 4; k++) r[c][k] = b;
      return r;
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NI; i++) begin
            if (iv[i] && ir[i]) begin
               exp_q[i].push_back(exp_next);
               acc_q[i].push_back(cyc + 1);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < NI; i++) begin
            exp_q[i].delete();
            acc_q[i].delete();
         end
         ov_prev <= '0;
      end else begin
         for (int i = 0; i < NI; i++) begin
            if (ov[i] && !ov_prev[i]) begin
               if (acc_q[i].size() == 0) fail($sformatf("L%0d unexpected o_valid", LANES_TAB[i]));
               else chk($sformatf("L%0d latency", LANES_TAB[i]), 128'(cyc - acc_q[i].pop_front()),
                        128'(16 / LANES_TAB[i]));
            end
            if (ov[i] && orr[i]) begin
               if (exp_q[i].size() == 0) fail($sformatf("L%0d unexpected output", LANES_TAB[i]));
               else chk($sformatf("L%0d data", LANES_TAB[i]), o_w[i], exp_q[i].pop_front());
            end
         end
         ov_prev <= ov;
      end
   end

   task automatic send(input logic [NI-1:0] mask, input state_t s, input state_t e);
      int t = 0;
      @(negedge clk);
      while (((ir & mask) != mask) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if ((ir & mask) != mask) begin
         fail("send ready timeout");
         return;
      end
      st = s;
      exp_next = e;
      iv = mask;
      @(posedge clk);
      #1 iv = '0;
   endtask

   task automatic drain();
      int t = 0;
      int busy = 1;
      while (busy != 0 && t < 200) begin
         @(negedge clk);
         t++;
         busy = 0;
         for (int i = 0; i < NI; i++) busy += exp_q[i].size();
      end
      if (busy != 0) fail("drain timeout");
   endtask

   localparam state_t FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam state_t FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      byte_t  vin  [6] = '{8'h00, 8'h01, 8'h53, 8'hff, 8'h19, 8'h3d};
      byte_t  vout [6] = '{8'h63, 8'h7c, 8'hed, 8'h16, 8'hd4, 8'h27};
      int     t;
      int     t_prev;
      state_t s;

      rst = 1'b1;
      iv  = '0;
      orr = '1;
      st  = '0;
      exp_next = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("L%0d reset o", LANES_TAB[i]), o_w[i], '0);
         chk($sformatf("L%0d reset i_ready", LANES_TAB[i]), ir[i], 1'b1);
         chk($sformatf("L%0d reset o_valid", LANES_TAB[i]), ov[i], 1'b0);
      end
      rst = 1'b0;

      // Uniform single-byte states on every lane count.
      for (int n = 0; n < 4; n++) begin
         send('1, fill(vin[n]), fill(vout[n]));
         drain();
      end

      send('1, FIPS_IN, FIPS_OUT);
      drain();

      // Backpressure on the LANES=4 instance.
      orr[2] = 1'b0;
      send(5'b00100, FIPS_IN, FIPS_OUT);
      t = 0;
      while (!ov[2] && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!ov[2]) fail("backpressure o_valid timeout");
      for (int n = 0; n < 10; n++) begin
         chk("bp o", o_w[2], FIPS_OUT);
         chk("bp o_valid", ov[2], 1'b1);
         chk("bp i_ready", ir[2], 1'b0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 orr[2] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp release i_ready", ir[2], 1'b1);
      chk("bp release o_valid", ov[2], 1'b0);
      drain();

      // Back-to-back on LANES=16 with i_valid held high.
      t_prev = 0;
      for (int n = 0; n < 6; n++) begin
         t = 0;
         while (!ir[4] && t < 20) begin
            @(negedge clk);
            t++;
         end
         if (!ir[4]) fail("b2b ready timeout");
         if (n > 0) chk("b2b interval", 128'(cyc - t_prev), 128'd3);
         t_prev = cyc;
         st = fill(vin[n]);
         exp_next = fill(vout[n]);
         iv[4] = 1'b1;
         @(posedge clk);
         #1;
      end
      iv[4] = 1'b0;
      drain();

      // Reset in the middle of a LANES=1 conversion, with idx at byte 7.
      send(5'b00001, FIPS_IN, FIPS_OUT);
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid-reset o", o_w[0], '0);
      chk("mid-reset i_ready", ir[0], 1'b1);
      chk("mid-reset o_valid", ov[0], 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      send(5'b00001, FIPS_IN, FIPS_OUT);
      drain();

      // Random sweep across all lane counts.
      for (int n = 0; n < 1000; n++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         send('1, s, ref_state(s));
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
